// File: rtl/abr_ctrl_pkg.sv
// Control-side types for the ABR memory arbiter: requester ids, command payload, read tag.
package abr_ctrl_pkg;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } abr_mem_arb_req_id_e;

    typedef struct packed {
        logic                              we;
        logic [abr_params_pkg::ADDR_W-1:0] addr;
        logic [abr_params_pkg::DATA_W-1:0] wdata;
        logic [abr_params_pkg::STRB_W-1:0] wstrobe;
    } abr_mem_cmd_t;

    typedef struct packed {
        logic                vld;
        abr_mem_arb_req_id_e id;
    } abr_mem_arb_tag_t;

endpackage

// File: rtl/abr_params_pkg.sv
// Shared SRAM geometry constants for the ABR memory subsystem.
package abr_params_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

endpackage

// File: rtl/abr_sram_be_if.sv
// Byte-enable SRAM port: one write and one read channel, 1-cycle read latency.
interface abr_sram_be_if #(
    parameter int unsigned ADDR_W = abr_params_pkg::ADDR_W,
    parameter int unsigned DATA_W = abr_params_pkg::DATA_W
);

    logic                  we_i;
    logic [ADDR_W-1:0]     waddr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [DATA_W/8-1:0]   wstrobe_i;
    logic                  re_i;
    logic [ADDR_W-1:0]     raddr_i;
    logic [DATA_W-1:0]     rdata_o;

    modport req (
        output we_i, waddr_i, wdata_i, wstrobe_i, re_i, raddr_i,
        input  rdata_o
    );

    modport mem (
        input  we_i, waddr_i, wdata_i, wstrobe_i, re_i, raddr_i,
        output rdata_o
    );

endinterface

// File: rtl/abr_rr_arb2.sv
// Two-way arbiter: round-robin by default, fixed priority (requester 0 wins)
// when ABR_MEM_ARB_FIXED_PRIO_EN is defined.
module abr_rr_arb2
    import abr_ctrl_pkg::*;
(
`ifndef ABR_MEM_ARB_FIXED_PRIO_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       zeroize_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c_o
);

`ifdef ABR_MEM_ARB_FIXED_PRIO_EN

    always_comb begin
        gnt_c_o = 2'b00;
        if (!zeroize_i) begin
            gnt_c_o[0] = req_i[0];
            gnt_c_o[1] = req_i[1] & ~req_i[0];
        end
    end

`else

    abr_mem_arb_req_id_e rr_q, rr_d;

    // rr_q names the requester preferred on a tie
    always_comb begin
        gnt_c_o = 2'b00;
        if (!zeroize_i) begin
            gnt_c_o[0] = req_i[0] & (~req_i[1] | (rr_q == REQ0));
            gnt_c_o[1] = req_i[1] & (~req_i[0] | (rr_q == REQ1));
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (zeroize_i) begin
            rr_d = REQ0;
        end else if (gnt_c_o[0]) begin
            rr_d = REQ1;
        end else if (gnt_c_o[1]) begin
            rr_d = REQ0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= REQ0;
        end else begin
            rr_q <= rr_d;
        end
    end

`endif

endmodule

// File: rtl/abr_mem_arb.sv
// Two-requester arbiter onto a byte-enable SRAM port with in-order read responses.
// ABR_MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module abr_mem_arb
    import abr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = abr_params_pkg::ADDR_W,
    parameter int unsigned DATA_W = abr_params_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        zeroize,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [1:0][ADDR_W-1:0]      req_addr,
    input  logic [1:0][DATA_W-1:0]      req_wdata,
    input  logic [1:0][DATA_W/8-1:0]    req_wstrobe,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    abr_sram_be_if.req                  sram
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [1:0]          gnt_c;
    logic                sel_c;
    abr_mem_arb_req_id_e gnt_id_c;
    abr_mem_cmd_t        cmd_c;

    logic                we_q, we_d;
    logic                re_q, re_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrobe_q, wstrobe_d;
    abr_mem_arb_tag_t    tag_q, tag_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;

    abr_rr_arb2 u_arb (
`ifndef ABR_MEM_ARB_FIXED_PRIO_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .zeroize_i (zeroize),
        .req_i     (req_valid),
        .gnt_c_o   (gnt_c)
    );

    assign req_ready = gnt_c;
    assign sel_c     = gnt_c[1];
    assign gnt_id_c  = abr_mem_arb_req_id_e'(sel_c);

    // Granted requester's command
    always_comb begin
        cmd_c.we      = req_we[sel_c];
        cmd_c.addr    = req_addr[sel_c];
        cmd_c.wdata   = req_wdata[sel_c];
        cmd_c.wstrobe = req_wstrobe[sel_c];
    end

    // Stage 1 tag rides with the SRAM command, stage 2 is the one-hot response strobe
    always_comb begin
        we_d        = 1'b0;
        re_d        = 1'b0;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        wdata_d     = wdata_q;
        wstrobe_d   = wstrobe_q;
        tag_d       = '0;
        rsp_valid_d = {tag_q.vld & (tag_q.id == REQ1), tag_q.vld & (tag_q.id == REQ0)};
        if (zeroize) begin
            waddr_d     = '0;
            raddr_d     = '0;
            wdata_d     = '0;
            wstrobe_d   = '0;
            rsp_valid_d = 2'b00;
        end else if (|gnt_c) begin
            if (cmd_c.we) begin
                we_d      = 1'b1;
                waddr_d   = cmd_c.addr;
                wdata_d   = cmd_c.wdata;
                wstrobe_d = cmd_c.wstrobe;
            end else begin
                re_d      = 1'b1;
                raddr_d   = cmd_c.addr;
                wstrobe_d = '0;
                tag_d.vld = 1'b1;
                tag_d.id  = gnt_id_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            wstrobe_q   <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 2'b00;
        end else begin
            we_q        <= we_d;
            re_q        <= re_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            wdata_q     <= wdata_d;
            wstrobe_q   <= wstrobe_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign sram.we_i      = we_q;
    assign sram.re_i      = re_q;
    assign sram.waddr_i   = waddr_q;
    assign sram.raddr_i   = raddr_q;
    assign sram.wdata_i   = wdata_q;
    assign sram.wstrobe_i = wstrobe_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = sram.rdata_o;

endmodule

// File: doc/abr_mem_arb.md
ABR_MEM_ARB -- requirements
Module: abr_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width (multiple of 8).
REQ-003 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have zeroize  input  1  synchronous clear of arbitration and in-flight state.
REQ-006 SHALL have req_valid  input  2  per-requester command valid.
REQ-007 SHALL have req_ready  output  2  per-requester command accepted.
REQ-008 SHALL have req_we  input  2  per-requester type (1 = write, 0 = read).
REQ-009 SHALL have req_addr  input  2xADDR_W  per-requester word address.
REQ-010 SHALL have req_wdata  input  2xDATA_W  per-requester write data.
REQ-011 SHALL have req_wstrobe  input  2xDATA_W/8  per-requester byte enables.
REQ-012 SHALL have rsp_valid  output  2  per-requester read data valid.
REQ-013 SHALL have rsp_rdata  output  DATA_W  read data, shared by both requesters.
REQ-014 SHALL have sram  abr_sram_be_if.req  -  byte-enable SRAM port driven by this block (we_i, waddr_i, wdata_i, wstrobe_i, re_i, raddr_i out; rdata_o in).

Function
REQ-015 SHALL grant at most one requester per cycle; req_ready[i] = grant[i], combinational from req_valid and rr_q.
REQ-016 SHALL accept a command in cycle N when req_valid[i] & req_ready[i].
REQ-017 SHALL register an accepted command and present it on sram in cycle N+1 for exactly one cycle.
REQ-018 SHALL drive the write fields on sram for an accepted write: we_i=1, waddr_i=addr, wdata_i=wdata, wstrobe_i=wstrobe, re_i=0.
REQ-019 SHALL drive the read fields on sram for an accepted read: re_i=1, raddr_i=addr, we_i=0, wstrobe_i=0.
REQ-020 SHALL drive we_i=0 and re_i=0 in any cycle with no accepted command, and hold the address/data fields at their last values.
REQ-021 SHALL treat SRAM read latency as 1 cycle: rdata_o valid in N+2; rsp_valid[id] SHALL assert in N+2 for one cycle, with rsp_rdata = sram.rdata_o combinationally.
REQ-022 SHALL track the requester id through a 2-stage tag pipeline; back-to-back reads SHALL sustain 1 response per cycle, in order.
REQ-023 SHALL never assert rsp_valid for writes.
REQ-024 SHALL use round-robin: rr_q is the preferred requester; when both are valid, grant rr_q; after any grant to i, rr_q <= ~i; if only one is valid, grant it.
REQ-025 SHALL update rr_q, when only one requester is valid, exactly as in REQ-024.
REQ-026 SHALL have no response backpressure; a requester SHALL sink rsp_valid unconditionally.
REQ-027 SHALL, on zeroize: req_ready=0 that cycle; next cycle we_i=re_i=0; rr_q=0; tag pipeline cleared, so in-flight rsp_valid is suppressed; wdata/addr/wstrobe registers = 0.
REQ-028 SHALL let zeroize win over simultaneous req_valid; nothing is accepted.

Reset
REQ-029 SHALL, while rst=1, drive we_i=0, re_i=0, waddr_i=0, raddr_i=0, wdata_i=0, wstrobe_i=0, rsp_valid=0, rr_q=0, tags=0.
REQ-030 SHALL drop in-flight reads on assertion of rst mid-operation; no rsp_valid after release until a new read is accepted.

Configuration
REQ-031 SHALL, when ABR_MEM_ARB_FIXED_PRIO_EN is defined, use fixed priority: requester 0 always wins, and rr_q is absent.
REQ-032 SHALL, when ABR_MEM_ARB_FIXED_PRIO_EN is undefined, use round-robin per REQ-024; all other behaviour is identical.

Structure
REQ-033 SHALL place abr_mem_arb_req_id_e (REQ0/REQ1) and the command struct (we, addr, wdata, wstrobe) in abr_ctrl_pkg, with the command struct parameterised through ADDR_W/DATA_W constants held in abr_params_pkg.
REQ-034 SHALL contain one sub-module, abr_rr_arb2 (2-way round-robin/fixed arbiter holding rr_q); all other logic is inline.

Verification
REQ-035 SHALL cover: req0 read addr 0x10, sram.rdata_o=0xA5A5A5A5 at N+2 -> re_i=1/raddr_i=0x10 at N+1, rsp_valid=2'b01 with rsp_rdata 0xA5A5A5A5 at N+2.
REQ-036 SHALL cover: both valid for 4 cycles, reads from rr_q=0 -> grants 0,1,0,1; rsp_valid 01,10,01,10 from cycle 2; with FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-037 SHALL cover: req1 write addr 0x3, wdata 0xDEADBEEF, wstrobe 4'b0011 -> next cycle we_i=1, wstrobe_i=0011, re_i=0; no rsp_valid.
REQ-038 SHALL cover: read accepted at N, zeroize at N+1 -> no rsp_valid at N+2; rr_q=0; we_i=re_i=0 at N+2.
REQ-039 SHALL cover: rst asserted asynchronously mid-stream of 3 reads -> all outputs 0 immediately; no stray rsp_valid after release.
